// File: rtl/duty_pwm_gen_pkg.sv
// Shared definitions for the double-buffered PWM generator: state encoding and defaults.
package duty_pwm_gen_pkg;

  localparam int unsigned CntW      = 12;
  localparam int unsigned DefPeriod = 4095;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StRun      = 2'b01,
    StStopPend = 2'b10
  } pwm_state_e;

endpackage

// File: rtl/pwm_shadow_buf.sv
// Pending duty/period buffer with Load/Load_Ack handshake; hands its contents to the
// active registers when the generator signals a safe apply point.
module pwm_shadow_buf
  import duty_pwm_gen_pkg::*;
#(
  parameter int unsigned Width = CntW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] duty_i,
  input  logic [Width-1:0] period_i,
  input  logic             apply_en_i,
  output logic             load_ack_o,
  output logic             apply_o,
  output logic [Width-1:0] pend_duty_o,
  output logic [Width-1:0] pend_period_o
);

  logic             pend_valid_q, pend_valid_d;
  logic [Width-1:0] pend_duty_q, pend_duty_d;
  logic [Width-1:0] pend_period_q, pend_period_d;
  logic             load_ack_q, load_ack_d;
  logic             capture;
  logic             apply;

  // Capture needs an empty buffer, apply needs a full one, so they never coincide;
  // a Load arriving on an apply cycle is naturally held off until the next cycle.
  always_comb begin
    capture       = load_i && !pend_valid_q;
    apply         = pend_valid_q && apply_en_i;
    pend_valid_d  = pend_valid_q;
    pend_duty_d   = pend_duty_q;
    pend_period_d = pend_period_q;
    load_ack_d    = capture;
    if (capture) begin
      pend_valid_d  = 1'b1;
      pend_duty_d   = duty_i;
      pend_period_d = period_i;
    end else if (apply) begin
      pend_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid_q  <= 1'b0;
      pend_duty_q   <= '0;
      pend_period_q <= '0;
      load_ack_q    <= 1'b0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_duty_q   <= pend_duty_d;
      pend_period_q <= pend_period_d;
      load_ack_q    <= load_ack_d;
    end
  end

  assign load_ack_o    = load_ack_q;
  assign apply_o       = apply;
  assign pend_duty_o   = pend_duty_q;
  assign pend_period_o = pend_period_q;

endmodule

// File: rtl/duty_pwm_gen.sv
// Free-running PWM generator; duty/period changes take effect only at period boundaries
// (or immediately while idle), so the waveform never glitches.
module duty_pwm_gen
  import duty_pwm_gen_pkg::*;
#(
  parameter int unsigned CNT_W      = CntW,
  parameter int unsigned DEF_PERIOD = DefPeriod
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [CNT_W-1:0] Duty,
  input  logic [CNT_W-1:0] Period,
  input  logic             Load,
  output logic             Load_Ack,
  input  logic             Run,
  output logic             PWM_Out,
  output logic             Cycle_Start,
  output logic             Busy
);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_duty_q, act_duty_d;
  logic [CNT_W-1:0] act_period_q, act_period_d;
  logic             pwm_q, pwm_d;
  logic             cs_q, cs_d;
  logic             active;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] pend_duty;
  logic [CNT_W-1:0] pend_period;

  pwm_shadow_buf #(
    .Width(CNT_W)
  ) u_shadow (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .load_i       (Load),
    .duty_i       (Duty),
    .period_i     (Period),
    .apply_en_i   (!active || wrap),
    .load_ack_o   (Load_Ack),
    .apply_o      (apply),
    .pend_duty_o  (pend_duty),
    .pend_period_o(pend_period)
  );

  always_comb begin
    active       = (state_q != StIdle);
    wrap         = active && (cnt_q == act_period_q);
    state_d      = state_q;
    cnt_d        = (!active || wrap) ? '0 : cnt_q + CNT_W'(1);
    act_duty_d   = apply ? pend_duty : act_duty_q;
    act_period_d = apply ? pend_period : act_period_q;
    pwm_d        = active && (cnt_q < act_duty_q);
    cs_d         = active && (cnt_q == '0);
    // Run only gates period starts; a running period always completes.
    unique case (state_q)
      StIdle:     if (Run) state_d = StRun;
      StRun:      if (!Run) state_d = StStopPend;
      StStopPend: begin
        if (Run)       state_d = StRun;
        else if (wrap) state_d = StIdle;
      end
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      act_duty_q   <= '0;
      act_period_q <= CNT_W'(DEF_PERIOD);
      pwm_q        <= 1'b0;
      cs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      act_duty_q   <= act_duty_d;
      act_period_q <= act_period_d;
      pwm_q        <= pwm_d;
      cs_q         <= cs_d;
    end
  end

  assign PWM_Out     = pwm_q;
  assign Cycle_Start = cs_q;
  assign Busy        = (state_q != StIdle);

endmodule

// File: tb/tb_duty_pwm_gen.sv
// Scoreboard bench: stimulus queues expected (length, high-time) per PWM period and a
// negedge monitor measures each period delimited by Cycle_Start and Busy.
module tb_duty_pwm_gen;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Load  = 1'b0;
  logic        Run   = 1'b0;
  logic [11:0] Duty  = '0;
  logic [11:0] Period = '0;
  logic        Load_Ack, PWM_Out, Cycle_Start, Busy;

  typedef struct {
    int    len;
    int    high;
    string tag;
  } per_t;

  per_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   open = 1'b0;
  bit   busy_prev = 1'b0;
  int   len = 0;
  int   high = 0;

  always #5 Clock = ~Clock;

  duty_pwm_gen #(
    .CNT_W     (12),
    .DEF_PERIOD(4095)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Duty       (Duty),
    .Period     (Period),
    .Load       (Load),
    .Load_Ack   (Load_Ack),
    .Run        (Run),
    .PWM_Out    (PWM_Out),
    .Cycle_Start(Cycle_Start),
    .Busy       (Busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic close_period();
    per_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL period: unexpected period len %0d high %0d", len, high);
    end else begin
      e = exp_q.pop_front();
      if (len != e.len || high != e.high) begin
        errors++;
        $display("FAIL period_%s: got len %0d high %0d expected len %0d high %0d",
                 e.tag, len, high, e.len, e.high);
      end
    end
  endtask

  // Outputs of cycle k describe the state of cycle k-1, hence busy_prev.
  always @(negedge Clock) begin
    if (Reset) begin
      open      = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (busy_prev) begin
        if (Cycle_Start) begin
          if (open) close_period();
          open = 1'b1;
          len  = 0;
          high = 0;
        end
        if (open) begin
          len++;
          high += int'(PWM_Out);
        end else begin
          chk("first_cycle_start", int'(Cycle_Start), 1);
        end
      end else begin
        if (open) close_period();
        open = 1'b0;
        chk("idle_outputs", int'({PWM_Out, Cycle_Start}), 0);
      end
      busy_prev = Busy;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic expect_periods(input int n, input int l, input int h, input string tag);
    per_t e;
    e.len = l; e.high = h; e.tag = tag;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic wait_cs(input int n, input int budget, input string name);
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      tick();
      t++;
      if (Cycle_Start) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, got %0d cycle starts required %0d", name, seen, n);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (Busy && t < budget) begin
      tick();
      t++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, Busy got 1 required 0", name);
    end
    repeat (3) tick();
  endtask

  task automatic do_load(input int d, input int p, input int exp_lat, input string name);
    int lat = 0;
    Duty = 12'(d);
    Period = 12'(p);
    Load = 1'b1;
    do begin
      tick();
      lat++;
    end while (!Load_Ack && lat < 50);
    Load = 1'b0;
    chk({name, "_ack_latency"}, lat, exp_lat);
    tick();
    chk({name, "_ack_pulse_width"}, int'(Load_Ack), 0);
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) tick();
    chk("reset_pwm", int'(PWM_Out), 0);
    chk("reset_cs", int'(Cycle_Start), 0);
    chk("reset_busy", int'(Busy), 0);
    chk("reset_ack", int'(Load_Ack), 0);
    Reset = 1'b0;

    // Defaults: period 4095, duty 0
    expect_periods(2, 4096, 0, "default");
    Run = 1'b1;
    tick();
    chk("busy_after_run", int'(Busy), 1);
    wait_cs(2, 10000, "default_cs");
    Run = 1'b0;
    wait_idle(5000, "default_idle");

    // Duty 3 / Period 9 loaded while idle
    do_load(3, 9, 1, "load_3_9");
    expect_periods(1, 10, 3, "d3p9");
    expect_periods(1, 5, 5, "d5p4");
    expect_periods(1, 7, 2, "d2p6");
    Run = 1'b1;
    wait_cs(1, 50, "d3p9_cs");
    tick();
    tick();
    // Mid-period reload: immediate ack, then back-pressure on a second load
    Duty = 12'd5; Period = 12'd4; Load = 1'b1;
    tick();
    chk("midload_ack", int'(Load_Ack), 1);
    Duty = 12'd2; Period = 12'd6;
    n = 0;
    do begin
      tick();
      n++;
    end while (!Load_Ack && n < 30);
    chk("backpressure_ack_latency", n, 7);
    chk("backpressure_ack_at_wrap", int'(Cycle_Start), 1);
    Load = 1'b0;
    tick();
    chk("backpressure_ack_pulse", int'(Load_Ack), 0);
    wait_cs(1, 50, "d2p6_cs");
    Run = 1'b0;
    wait_idle(100, "reload_idle");

    // Run dropped at cnt=2, reasserted at cnt=6, then dropped for good
    do_load(3, 9, 1, "load_stop");
    expect_periods(2, 10, 3, "stop_pend");
    Run = 1'b1;
    wait_cs(1, 50, "stop_cs1");
    tick();
    Run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busy_in_stop_pend", int'(Busy), 1);
    end
    Run = 1'b1;
    wait_cs(1, 50, "stop_cs2");
    tick();
    Run = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (Busy && n < 30);
    chk("busy_fall_latency", n, 8);
    chk("pwm_at_busy_fall", int'(PWM_Out), 0);
    repeat (3) tick();
    chk("pwm_idle_after_stop", int'(PWM_Out), 0);

    // Duty 0 always low
    do_load(0, 5, 1, "load_d0");
    expect_periods(2, 6, 0, "duty0");
    Run = 1'b1;
    wait_cs(2, 50, "duty0_cs");
    Run = 1'b0;
    wait_idle(50, "duty0_idle");

    // Period 0 duty 1: constant high, Cycle_Start every clock; drop after 3 adds 2 more
    do_load(1, 0, 1, "load_p0");
    expect_periods(5, 1, 1, "period0");
    Run = 1'b1;
    wait_cs(3, 50, "period0_cs");
    chk("period0_pwm_high", int'(PWM_Out), 1);
    Run = 1'b0;
    wait_idle(50, "period0_idle");

    // Reset mid-period with a pending load: pending discarded, defaults restored
    do_load(3, 9, 1, "load_pre_reset");
    Run = 1'b1;
    wait_cs(1, 50, "pre_reset_cs");
    tick();
    tick();
    do_load(7, 8, 1, "load_pending");
    Reset = 1'b1;
    Run = 1'b0;
    tick();
    chk("midreset_pwm", int'(PWM_Out), 0);
    chk("midreset_cs", int'(Cycle_Start), 0);
    chk("midreset_busy", int'(Busy), 0);
    chk("midreset_ack", int'(Load_Ack), 0);
    Reset = 1'b0;
    tick();
    expect_periods(1, 4096, 0, "post_reset");
    Run = 1'b1;
    wait_cs(1, 50, "post_reset_cs");
    Run = 1'b0;
    wait_idle(5000, "post_reset_idle");

    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/duty_pwm_gen.md
Name: duty_pwm_gen

Overview:
Downstream consumer of the 12-bit duty-voltage path stage (DUTYS_VPath). Converts the latched 12-bit duty code plus a 12-bit period code into a free-running PWM waveform for the output analog stage. Duty and period are double-buffered: a load handshake captures new values into a pending buffer, and the buffer is applied only at a period boundary, so the waveform never glitches.

Parameters:
CNT_W, 12, width of duty, period and counter
DEF_PERIOD, 4095, active period after reset

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Duty  input  CNT_W  duty code from the duty path (high-time in clocks)
Period  input  CNT_W  period code; period length = Period+1 clocks
Load  input  1  request to capture Duty/Period; held until Load_Ack
Load_Ack  output  1  one-cycle pulse, capture accepted
Run  input  1  level: enable PWM generation
PWM_Out  output  1  registered PWM output
Cycle_Start  output  1  one-cycle pulse at each period start while running
Busy  output  1  high in RUN or STOP_PEND states

Behaviour:
- Reset (sync, high): state=IDLE, cnt=0, act_duty=0, act_period=DEF_PERIOD, pend_valid=0, PWM_Out=0, Load_Ack=0, Cycle_Start=0, Busy=0. Reset mid-period aborts immediately; pending load is discarded.
- Pending buffer: on Load=1 && pend_valid=0, capture Duty/Period into pend regs, set pend_valid, pulse Load_Ack the next cycle (1 clk). If Load=1 && pend_valid=1: no capture, no ack (back-pressure) until the buffer is consumed.
- Apply: pend→act and clear pend_valid (a) the cycle after capture when state=IDLE, (b) at a wrap (cnt==act_period) in RUN/STOP_PEND. A Load capture in the same cycle as the apply: apply the older pend value; the new capture is held off one cycle.
- States: IDLE → RUN when Run=1 (cnt starts at 0 the next cycle). RUN → STOP_PEND when Run=0. STOP_PEND → RUN if Run returns to 1 before wrap; → IDLE at wrap. A period is never truncated by Run.
- Counter: in RUN/STOP_PEND, cnt increments by 1; at cnt==act_period it wraps to 0. Held at 0 in IDLE. Period=0 gives a 1-clock period.
- PWM_Out (1-clk latency): PWM_Out(k+1) = (state!=IDLE) && (cnt(k) < act_duty(k)). act_duty=0 → always low. act_duty>act_period → always high. Forced low in IDLE.
- Cycle_Start(k+1) = (state!=IDLE) && cnt(k)==0.
- Busy = state!=IDLE (registered with state).
- All comparisons unsigned, CNT_W wide; no overflow possible since cnt ≤ act_period.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, RUN=2'b01, STOP_PEND=2'b10), CNT_W default, DEF_PERIOD.
- One natural sub-module: pwm_shadow_buf (pending regs, pend_valid, Load/Load_Ack handshake, apply strobe); counter, FSM and compare stay in the top module.

Test Plan:
- Reset then Run=1 with no load: act_period=4095, act_duty=0 → PWM_Out stays 0; Cycle_Start pulses every 4096 clocks.
- In IDLE, Load with Duty=3, Period=9, then Run=1 → PWM_Out high for 3 clocks, low for 7, repeating every 10 clocks; Load_Ack is a single-cycle pulse.
- While running Duty=3/Period=9, load Duty=5/Period=4 mid-period → the current 10-clock period completes unchanged; the next period is 5 clocks with 5 high (always high, since duty>period); a second Load while pend_valid=1 gets no ack until the wrap.
- Run dropped at cnt=2 of Period=9 → period completes to cnt=9, Busy falls, PWM_Out=0; Run reasserted at cnt=6 → stays in RUN with no gap.
- Edge cases: Duty=0 → always low; Period=0 with Duty=1 → constant high with Cycle_Start every clock.
- Reset asserted mid-period with pend_valid=1 → next cycle all outputs 0 and pending discarded (a later Run uses DEF_PERIOD with duty 0).
